// File: rtl/move_resolver.sv
// Turn-stage move resolver: decodes the attacker's move, checks special budget,
// rolls dodge from an internal LFSR and pulses stat-block enables. Optional crit: CRIT_EN.
module move_resolver #(
  parameter logic [5:0] STRIKE_DMG = 6'd8,
  parameter logic [5:0] HEAVY_DMG  = 6'd16,
  parameter logic [5:0] BLAST_DMG  = 6'd31,
  parameter logic [5:0] HEAL_AMT   = 6'd20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] move,
  input  logic [4:0] atk_special,
  input  logic [4:0] def_dodge,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic       missed,
  output logic [4:0] roll,
  output logic [5:0] def_hit,
  output logic [5:0] atk_hit,
  output logic [2:0] atk_cost,
  output logic       def_en,
  output logic       atk_en
);

  typedef enum logic [2:0] {IDLE, CHECK, ROLL, APPLY, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] lfsr;
  logic [2:0] move_q;
  logic [4:0] special_q;
  logic [4:0] dodge_q;
  logic       reject_q;
  logic       missed_q;
  logic [5:0] hit_q;
  logic [4:0] roll_q;

  logic [5:0] dmg;
  logic [5:0] self_hit;
  logic [2:0] cost;
  logic       reject_cond;
  logic       miss_cond;
  logic [5:0] hit_calc;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    dmg      = 6'd0;
    self_hit = 6'd0;
    cost     = 3'd0;
    case (move_q)
      3'd0: dmg = STRIKE_DMG;
      3'd1: begin dmg = HEAVY_DMG; cost = 3'b010; end
      3'd2: begin dmg = BLAST_DMG; cost = 3'b011; end
      3'd3: begin self_hit = 6'd0 - HEAL_AMT; cost = 3'b011; end
      3'd4: cost = 3'b100;
      3'd5: cost = 3'b111;
      default: ;
    endcase
  end

  // Only positive costs are spends; negative costs regain special and never refuse.
  assign reject_cond = !cost[2] && (cost != 3'd0) && (special_q < {2'b00, cost});
  assign miss_cond   = (dmg != 6'd0) && (lfsr[4:0] < dodge_q);

`ifdef CRIT_EN
  logic [6:0] dmg_dbl;
  always_comb begin
    dmg_dbl = {dmg, 1'b0};
    if (miss_cond)
      hit_calc = 6'd0;
    else if (lfsr[4:0] == 5'd31)
      hit_calc = (dmg_dbl > 7'd31) ? 6'd31 : dmg_dbl[5:0];
    else
      hit_calc = dmg;
  end
`else
  assign hit_calc = miss_cond ? 6'd0 : dmg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      move_q    <= 3'd0;
      special_q <= 5'd0;
      dodge_q   <= 5'd0;
      reject_q  <= 1'b0;
      missed_q  <= 1'b0;
      hit_q     <= 6'd0;
      roll_q    <= 5'd0;
    end else begin
      state <= state_next;
      lfsr  <= {lfsr[6:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (start) begin
            move_q    <= move;
            special_q <= atk_special;
            dodge_q   <= def_dodge;
            reject_q  <= 1'b0;
            missed_q  <= 1'b0;
          end
        end
        CHECK: reject_q <= reject_cond;
        ROLL: begin
          roll_q   <= lfsr[4:0];
          missed_q <= miss_cond;
          hit_q    <= hit_calc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = reject_cond ? DONE : ROLL;
      ROLL:    state_next = APPLY;
      APPLY:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state so an asynchronous reset clears them at once.
  always_comb begin
    busy     = (state != IDLE);
    done     = 1'b0;
    reject   = 1'b0;
    missed   = 1'b0;
    def_hit  = 6'd0;
    atk_hit  = 6'd0;
    atk_cost = 3'd0;
    def_en   = 1'b0;
    atk_en   = 1'b0;
    case (state)
      APPLY: begin
        def_en   = 1'b1;
        atk_en   = 1'b1;
        def_hit  = hit_q;
        atk_hit  = self_hit;
        atk_cost = cost;
      end
      DONE: begin
        done   = 1'b1;
        reject = reject_q;
        missed = missed_q;
      end
      default: ;
    endcase
  end

  assign roll = roll_q;

endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver: latency, reject path, heal/focus/guard, dodge
// boundaries, reset mid-operation and crit timing.
module tb_move_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] move;
  logic [4:0] atk_special;
  logic [4:0] def_dodge;
  logic       busy, done, reject, missed, def_en, atk_en;
  logic [4:0] roll;
  logic [5:0] def_hit, atk_hit;
  logic [2:0] atk_cost;

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl;
  logic [4:0] pr;

  move_resolver dut (
    .clk(clk), .rst(rst), .start(start), .move(move),
    .atk_special(atk_special), .def_dodge(def_dodge),
    .busy(busy), .done(done), .reject(reject), .missed(missed),
    .roll(roll), .def_hit(def_hit), .atk_hit(atk_hit), .atk_cost(atk_cost),
    .def_en(def_en), .atk_en(atk_en)
  );

  always #5 clk = ~clk;

  // Reference LFSR: Fibonacci, taps 8,6,5,4, shifting toward the MSB.
  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [4:0] pred_roll(input logic [7:0] x);
    logic [7:0] y;
    y = nx(nx(x));
    return y[4:0];
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) mdl <= 8'hA5;
    else     mdl <= nx(mdl);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start in the current cycle, then scramble inputs to prove they were latched.
  task automatic go(input logic [2:0] mv, input logic [4:0] sp, input logic [4:0] dg);
    move = mv; atk_special = sp; def_dodge = dg; start = 1'b1;
    @(negedge clk);
    start = 1'b0; move = ~mv; atk_special = ~sp; def_dodge = ~dg;
  endtask

  task automatic wait_roll(input bit want31);
    int n;
    n = 0;
    while (((pred_roll(mdl) == 5'd31) != want31) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("roll_wait", 32'(n < 400), 32'd1);
  endtask

  task automatic run_ok(input string tag, input logic [2:0] mv, input logic [4:0] sp,
                        input logic [4:0] dg, input logic [5:0] ehit, input logic [5:0] eatk,
                        input logic [2:0] ecost, input logic emiss);
    logic [4:0] er;
    er = pred_roll(mdl);
    go(mv, sp, dg);
    chk({tag, "_c1_busy"}, 32'(busy), 32'd1);
    chk({tag, "_c1_en"}, 32'(def_en), 32'd0);
    @(negedge clk);
    chk({tag, "_c2_en"}, 32'(atk_en), 32'd0);
    @(negedge clk);
    chk({tag, "_def_en"}, 32'(def_en), 32'd1);
    chk({tag, "_atk_en"}, 32'(atk_en), 32'd1);
    chk({tag, "_def_hit"}, 32'(def_hit), 32'(ehit));
    chk({tag, "_atk_hit"}, 32'(atk_hit), 32'(eatk));
    chk({tag, "_atk_cost"}, 32'(atk_cost), 32'(ecost));
    chk({tag, "_roll"}, 32'(roll), 32'(er));
    chk({tag, "_c3_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_reject"}, 32'(reject), 32'd0);
    chk({tag, "_missed"}, 32'(missed), 32'(emiss));
    chk({tag, "_c4_en"}, 32'(def_en), 32'd0);
    chk({tag, "_c4_hit"}, 32'(def_hit), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    $display("txn %s move=%0d roll=%0d exp_def_hit=%0d exp_missed=%0d", tag, mv, er, ehit, emiss);
  endtask

  // Refused move, with a start offered during DONE that must be ignored.
  task automatic run_rej(input string tag, input logic [2:0] mv, input logic [4:0] sp);
    go(mv, sp, 5'd0);
    chk({tag, "_c1_busy"}, 32'(busy), 32'd1);
    chk({tag, "_c1_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_reject"}, 32'(reject), 32'd1);
    chk({tag, "_missed"}, 32'(missed), 32'd0);
    chk({tag, "_def_en"}, 32'(def_en), 32'd0);
    chk({tag, "_atk_en"}, 32'(atk_en), 32'd0);
    chk({tag, "_def_hit"}, 32'(def_hit), 32'd0);
    chk({tag, "_atk_cost"}, 32'(atk_cost), 32'd0);
    move = 3'd0; atk_special = 5'd31; def_dodge = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_b2b_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_b2b_busy2"}, 32'(busy), 32'd0);
    chk({tag, "_b2b_en"}, 32'(def_en), 32'd0);
    $display("txn %s move=%0d special=%0d exp_reject=1", tag, mv, sp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; move = 3'd0; atk_special = 5'd0; def_dodge = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_def_en", 32'(def_en), 32'd0);
    chk("rst_roll", 32'(roll), 32'd0);
    chk("rst_def_hit", 32'(def_hit), 32'd0);
    chk("rst_atk_cost", 32'(atk_cost), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    wait_roll(1'b0);
    run_ok("strike", 3'd0, 5'd10, 5'd0, 6'd8, 6'd0, 3'b000, 1'b0);
    run_rej("heavy_rej", 3'd1, 5'd1);
    wait_roll(1'b0);
    run_ok("heavy_edge", 3'd1, 5'd2, 5'd0, 6'd16, 6'd0, 3'b010, 1'b0);
    run_ok("heal", 3'd3, 5'd5, 5'd31, 6'd0, 6'b101100, 3'b011, 1'b0);
    run_ok("focus", 3'd4, 5'd0, 5'd0, 6'd0, 6'd0, 3'b100, 1'b0);
    run_ok("guard", 3'd5, 5'd0, 5'd0, 6'd0, 6'd0, 3'b111, 1'b0);
    run_ok("nop", 3'd6, 5'd0, 5'd0, 6'd0, 6'd0, 3'b000, 1'b0);
    wait_roll(1'b0);
    run_ok("blast_miss", 3'd2, 5'd3, 5'd31, 6'd0, 6'd0, 3'b011, 1'b1);
    wait_roll(1'b0);
    pr = pred_roll(mdl);
    run_ok("dodge_eq", 3'd0, 5'd0, pr, 6'd8, 6'd0, 3'b000, 1'b0);
    wait_roll(1'b0);
    pr = pred_roll(mdl);
    run_ok("dodge_above", 3'd0, 5'd0, pr + 5'd1, 6'd0, 6'd0, 3'b000, 1'b1);

    // Reset asserted while in ROLL.
    go(3'd0, 5'd10, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_def_en", 32'(def_en), 32'd0);
    chk("midrst_atk_en", 32'(atk_en), 32'd0);
    chk("midrst_roll", 32'(roll), 32'd0);
    @(negedge clk);
    chk("midrst_en2", 32'(def_en), 32'd0);
    rst = 1'b0;
    // Seed A5 -> 4A -> 95, so the first roll after reset is 5'b10101.
    go(3'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reseed_roll", 32'(roll), 32'd21);
    chk("reseed_def_hit", 32'(def_hit), 32'd8);
    chk("reseed_def_en", 32'(def_en), 32'd1);
    @(negedge clk);
    chk("reseed_done", 32'(done), 32'd1);
    @(negedge clk);
    $display("txn reseed move=0 exp_roll=21 exp_def_hit=8");

    wait_roll(1'b1);
`ifdef CRIT_EN
    run_ok("crit", 3'd1, 5'd31, 5'd0, 6'd31, 6'd0, 3'b010, 1'b0);
`else
    run_ok("crit", 3'd1, 5'd31, 5'd0, 6'd16, 6'd0, 3'b010, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
